jzjpcc_memory_stage_lsu: RTL and testbench
==========================================

Name: jzjpcc_memory_stage_lsu

Overview:
- Memory-stage load/store unit. Sits directly downstream of the execute stage and drives port B of the shared inferred SRAM in the memory backend; port A is used for instruction fetch.
- Decodes the byte address into RAM, MMIO or unmapped space, and generates the SRAM byte mask and byte-swapped write data.
- Owns the 8 MMIO output registers.
- Returns aligned, sign- or zero-extended load data one cycle later, in the writeback stage.

Parameters:
- RAM_A_WIDTH, 12: SRAM word-address width. RAM spans byte addresses 0 to 4*2^RAM_A_WIDTH-1.
- MMIO_BASE, 32'hFFFFFFE0: byte base of 8 consecutive MMIO words. Must be 32-byte aligned.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- stall  in  1  hold the memory stage; no new request accepted
- memRead  in  1  load request this cycle
- memWrite  in  1  store request this cycle (memRead and memWrite both high = fault)
- funct3  in  3  RISC-V load/store funct3
- address  in  32  byte address
- writeData  in  32  store value, little-endian numeric
- sramAddressB  out  RAM_A_WIDTH  SRAM port B word address
- sramWriteEnableB  out  1  SRAM port B write enable
- sramByteMaskB  out  4  bit i enables raw bits [8i+7:8i]
- sramWriteB  out  32  raw SRAM write word
- sramReadB  in  32  raw SRAM read word (1-cycle synchronous)
- loadData  out  32  formatted load result, valid in the cycle after the request
- misaligned  out  1  pulses in the response cycle
- accessFault  out  1  pulses in the response cycle
- faultStatus  out  2  sticky {accessFault, misaligned}; see Optional Feature
- mmioInputs  in  32x8  MMIO input words
- mmioOutputs  out  32x8  MMIO output registers

Behaviour:
- Byte order: a raw SRAM word is the byte-swap of the core value. Byte offset k maps to raw lane 3-k (mask bit 3-k).
- Accepted request: memRead|memWrite high and stall low.
- Address decode:
  - RAM if address < 4*2^RAM_A_WIDTH.
  - MMIO if address[31:5] == MMIO_BASE[31:5]; index = address[4:2].
  - Otherwise unmapped.
- funct3 legality:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is an access fault.
- Misalignment: halfword with address[0]=1, or word with address[1:0]≠0.
- Faulting or misaligned request:
  - No SRAM or MMIO write occurs.
  - The response cycle gives loadData=0 and pulses the matching flag for 1 cycle.
  - If both conditions hold, accessFault takes precedence.
- RAM store:
  - sramWriteEnableB=1 in the request cycle (combinational).
  - Mask: SB 1 lane; SH 2 lanes; SW 4'b1111.
  - Data replicated byte-swapped into the selected lanes.
- MMIO store: updates only the addressed bytes of mmioOutputs[index] at the clock edge. Other bytes hold their value.
- sramAddressB:
  - = address[RAM_A_WIDTH+1:2] on an accepted request.
  - Otherwise the registered last address, so sramReadB stays stable across stalls.
  - Reset value 0.
- Response registers, captured on an accepted load, cleared to "no load" on an accepted store or an idle non-stalled cycle, and held while stall=1:
  - load valid
  - funct3
  - byte offset
  - source (RAM/MMIO)
  - sampled mmioInputs[index]
  - fault flags
- loadData (combinational from the response registers plus sramReadB):
  - Selects the raw word, byte-swaps it, shifts by offset, then sign- or zero-extends by funct3.
  - Equals 0 when no load is registered.
- Reset values: all response registers clear, mmioOutputs all 0, loadData 0, flags 0, sramWriteEnableB 0.
- Reset takes priority over any simultaneous request; a store in the reset cycle is dropped.
- Pipelining: back-to-back loads deliver one result per cycle; a store followed by a load to the same word reads the new data.

Optional Feature:
- Macro: JZJPCC_LSU_STICKY_FAULT_EN.
- Defined: faultStatus bits set on their fault pulses, cleared only by reset.
- Undefined: faultStatus tied to 2'b00 and no sticky registers are synthesised.

Test Plan:
- SW 0x11223344 to 0x10, then LW 0x10: sramByteMaskB=1111, sramWriteB=0x44332211; loadData=0x11223344 in the next cycle.
- After the above, LB 0x13 -> 0x00000011; LH 0x12 -> 0x00001122. Then SB 0x80 to 0x11 and LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080.
- SH 0xBEEF to MMIO_BASE+6 -> mmioOutputs[1]=0xBEEF0000. Then LW MMIO_BASE+4 with mmioInputs[1]=0xCAFEF00D -> loadData=0xCAFEF00D.
- LW 0x2 -> misaligned pulse, loadData=0, no write. SW to 0x80000000 -> accessFault pulse, no SRAM write; faultStatus=11 when the macro is defined.
- LW 0x10 then stall=1 for 3 cycles with a changing address -> loadData holds 0x11223344, sramAddressB holds 4, no writes.
- SW to MMIO_BASE asserted in the same cycle as reset -> mmioOutputs[0] stays 0 and all outputs read 0.

Source files
------------

// File: rtl/jzjpcc_memory_stage_lsu.sv
// Memory-stage load/store unit for the jzjpcc core.
// - Drives port B of the shared SRAM.
// - Decodes each request into RAM, MMIO or unmapped space.
// - Builds the byte-swapped write word and lane mask.
// - Owns the eight MMIO output registers.
// - Formats load data one cycle after the request.
// Optional feature: define JZJPCC_LSU_STICKY_FAULT_EN for sticky fault status bits.
module jzjpcc_memory_stage_lsu #(
  parameter int          RAM_A_WIDTH = 12,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFFFFE0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   memRead,
  input  logic                   memWrite,
  input  logic [2:0]             funct3,
  input  logic [31:0]            address,
  input  logic [31:0]            writeData,
  output logic [RAM_A_WIDTH-1:0] sramAddressB,
  output logic                   sramWriteEnableB,
  output logic [3:0]             sramByteMaskB,
  output logic [31:0]            sramWriteB,
  input  logic [31:0]            sramReadB,
  output logic [31:0]            loadData,
  output logic                   misaligned,
  output logic                   accessFault,
  output logic [1:0]             faultStatus,
  input  logic [31:0]            mmioInputs  [8],
  output logic [31:0]            mmioOutputs [8]
);

  // Request decode
  logic       w_accept;
  logic       w_both;
  logic       w_in_ram;
  logic       w_in_mmio;
  logic       w_load_legal;
  logic       w_store_legal;
  logic       w_legal;
  logic       w_access_fault;
  logic       w_misaligned;
  logic       w_ok;
  logic       w_mmio_store;
  logic [2:0] w_mmio_index;
  logic [1:0] w_offset;
  logic [3:0] w_core_mask;
  logic [31:0] w_core_wdata;

  // Registered state
  logic [RAM_A_WIDTH-1:0] r_last_addr;
  logic                   r_load_valid;
  logic [2:0]             r_funct3;
  logic [1:0]             r_offset;
  logic                   r_src_mmio;
  logic [31:0]            r_mmio_data;
  logic                   r_access_fault;
  logic                   r_misaligned;
  logic [31:0]            r_mmio_out [8];

  // Load formatting
  logic [31:0] w_word;
  logic [31:0] w_shifted;
  logic [31:0] w_extended;

  // Reset blocks acceptance so a store in the reset cycle never lands anywhere.
  assign w_accept     = (memRead | memWrite) & ~stall & ~reset;
  assign w_both       = memRead & memWrite;
  assign w_in_ram     = (address[31:RAM_A_WIDTH+2] == '0);
  assign w_in_mmio    = (address[31:5] == MMIO_BASE[31:5]);
  assign w_mmio_index = address[4:2];
  assign w_offset     = address[1:0];

  assign w_load_legal  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign w_store_legal = funct3 inside {3'b000, 3'b001, 3'b010};
  assign w_legal       = memRead ? w_load_legal : w_store_legal;

  // Simultaneous read+write, bad funct3 or unmapped address all count as access faults.
  assign w_access_fault = w_both | ~w_legal | ~(w_in_ram | w_in_mmio);
  assign w_misaligned   = ((funct3[1:0] == 2'b01) & address[0]) |
                          ((funct3[1:0] == 2'b10) & (address[1:0] != 2'b00));
  assign w_ok           = w_accept & ~w_access_fault & ~w_misaligned;

  // RAM wins if the two regions ever overlap for an odd parameter choice.
  assign sramWriteEnableB = w_ok & memWrite & w_in_ram;
  assign w_mmio_store     = w_ok & memWrite & w_in_mmio & ~w_in_ram;

  // Core-order byte enables and replicated store data, before the lane swap.
  always_comb begin
    w_core_mask  = 4'b1111;
    w_core_wdata = writeData;
    case (funct3[1:0])
      2'b00: begin
        w_core_mask  = 4'b0001 << w_offset;
        w_core_wdata = {4{writeData[7:0]}};
      end
      2'b01: begin
        w_core_mask  = 4'b0011 << w_offset;
        w_core_wdata = {2{writeData[15:0]}};
      end
      default: begin
        w_core_mask  = 4'b1111;
        w_core_wdata = writeData;
      end
    endcase
  end

  // Core byte k lives in raw SRAM lane 3-k.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign sramByteMaskB[gi]          = w_core_mask[3-gi];
      assign sramWriteB[8*gi +: 8]      = w_core_wdata[8*(3-gi) +: 8];
    end
  endgenerate

  // Hold the last accepted word address so the SRAM read output stays stable through stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_addr <= '0;
    end else if (w_accept) begin
      r_last_addr <= address[RAM_A_WIDTH+1:2];
    end
  end

  assign sramAddressB = w_accept ? address[RAM_A_WIDTH+1:2] : r_last_addr;

  // Response registers: capture on any non-stalled cycle, hold while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_load_valid   <= 1'b0;
      r_funct3       <= 3'b000;
      r_offset       <= 2'b00;
      r_src_mmio     <= 1'b0;
      r_mmio_data    <= '0;
      r_access_fault <= 1'b0;
      r_misaligned   <= 1'b0;
    end else if (!stall) begin
      r_load_valid   <= w_ok & memRead;
      r_funct3       <= funct3;
      r_offset       <= w_offset;
      r_src_mmio     <= w_in_mmio & ~w_in_ram;
      r_mmio_data    <= mmioInputs[w_mmio_index];
      r_access_fault <= w_accept & w_access_fault;
      r_misaligned   <= w_accept & ~w_access_fault & w_misaligned;
    end
  end

  assign accessFault = r_access_fault;
  assign misaligned  = r_misaligned;

  // MMIO output registers: only the enabled bytes of the addressed word change.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_mmio_out[i] <= '0;
      end
    end else if (w_mmio_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_core_mask[b]) begin
          r_mmio_out[w_mmio_index][8*b +: 8] <= w_core_wdata[8*b +: 8];
        end
      end
    end
  end

  generate
    for (gi = 0; gi < 8; gi++) begin : g_mmio_out
      assign mmioOutputs[gi] = r_mmio_out[gi];
    end
  endgenerate

  // Bring the returned word into core byte order and right-align the addressed bytes.
  always_comb begin
    w_word    = r_src_mmio ? r_mmio_data
                           : {sramReadB[7:0], sramReadB[15:8], sramReadB[23:16], sramReadB[31:24]};
    w_shifted = w_word >> {r_offset, 3'b000};
  end

  // Sign- or zero-extend by access width; nothing comes out unless a good load is registered.
  always_comb begin
    w_extended = w_shifted;
    case (r_funct3)
      3'b000:  w_extended = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_extended = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_extended = {24'h000000, w_shifted[7:0]};
      3'b101:  w_extended = {16'h0000, w_shifted[15:0]};
      default: w_extended = w_shifted;
    endcase
    loadData = r_load_valid ? w_extended : 32'h0;
  end

`ifdef JZJPCC_LSU_STICKY_FAULT_EN
  logic [1:0] r_fault_status;

  // Sticky flags set at the same edge as the fault pulse; only reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fault_status <= 2'b00;
    end else if (!stall) begin
      r_fault_status <= r_fault_status |
                        {w_accept & w_access_fault, w_accept & ~w_access_fault & w_misaligned};
    end
  end

  assign faultStatus = r_fault_status;
`else
  assign faultStatus = 2'b00;
`endif

endmodule

// File: tb/tb_jzjpcc_memory_stage_lsu.sv
// Testbench for jzjpcc_memory_stage_lsu: directed steps then random traffic
// against a byte-level memory model; sticky status checked when
// JZJPCC_LSU_STICKY_FAULT_EN is defined.
module tb_jzjpcc_memory_stage_lsu;

  localparam logic [31:0] MMIO_BASE = 32'hFFFFFFE0;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [11:0] sramAddressB;
  logic        sramWriteEnableB;
  logic [3:0]  sramByteMaskB;
  logic [31:0] sramWriteB;
  logic [31:0] sramReadB;
  logic [31:0] loadData;
  logic        misaligned;
  logic        accessFault;
  logic [1:0]  faultStatus;
  logic [31:0] mmioInputs  [8];
  logic [31:0] mmioOutputs [8];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  ref_mem [int unsigned];
  logic [31:0] ref_mmio [8];
  logic [11:0] last_addr;
  logic [1:0]  ref_fs;

  // Request-cycle observations for directed constant checks
  logic [3:0]  last_mask;
  logic [31:0] last_wdata;
  logic        last_we;

  // Raw-order SRAM port B with one-cycle read latency
  logic [31:0] sram [0:4095];
  logic [31:0] sram_rd;
  bit          sram_init_done = 0;

  assign sramReadB = sram_rd;

  always #5 clock = ~clock;

  jzjpcc_memory_stage_lsu #(.RAM_A_WIDTH(12), .MMIO_BASE(MMIO_BASE)) dut (
    .clock(clock), .reset(reset), .stall(stall), .memRead(memRead), .memWrite(memWrite),
    .funct3(funct3), .address(address), .writeData(writeData),
    .sramAddressB(sramAddressB), .sramWriteEnableB(sramWriteEnableB),
    .sramByteMaskB(sramByteMaskB), .sramWriteB(sramWriteB), .sramReadB(sramReadB),
    .loadData(loadData), .misaligned(misaligned), .accessFault(accessFault),
    .faultStatus(faultStatus), .mmioInputs(mmioInputs), .mmioOutputs(mmioOutputs)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  always @(posedge clock) begin
    if (reset && !sram_init_done) begin
      for (int k = 0; k < 4096; k++) sram[k] <= 32'h0;
      sram_rd        <= 32'h0;
      sram_init_done <= 1'b1;
    end else begin
      if (sramWriteEnableB) sram[sramAddressB] <= merge(sram[sramAddressB], sramWriteB, sramByteMaskB);
      sram_rd <= sram[sramAddressB];
    end
  end

  function automatic logic [7:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request cycle plus its response cycle, checked against the byte-level model.
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] o_ld);
    bit          active, both, legal, in_ram, in_mmio, exp_af, exp_mis, ok, exp_we;
    int          size, off, idx, lane;
    logic [3:0]  exp_mask;
    logic [31:0] lane_bits, exp_raw, exp_ld, tmp, b;
    logic [11:0] exp_addr;
    memRead = rd; memWrite = wr; funct3 = f3; address = a; writeData = wd; stall = 1'b0;
    active  = rd || wr;
    both    = rd && wr;
    if (rd && !wr) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    else           legal = (f3 <= 2);
    in_ram  = (a < 32'h4000);
    in_mmio = (a >= MMIO_BASE);
    size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off     = int'(a % 4);
    idx     = int'((a - MMIO_BASE) >> 2) & 7;
    exp_af  = active && (both || !legal || !(in_ram || in_mmio));
    exp_mis = active && !exp_af && ((a % size) != 0);
    ok      = active && !exp_af && !exp_mis;
    exp_we  = ok && wr && in_ram;
    exp_addr = active ? a[13:2] : last_addr;
    if (active) last_addr = a[13:2];
    exp_ld = 32'h0;
    if (ok && rd) begin
      tmp = mmioInputs[idx];
      for (int i = 0; i < size; i++) begin
        b = in_ram ? 32'(ref_rd(a + i)) : ((tmp >> (8 * (off + i))) & 32'hFF);
        exp_ld = exp_ld | (b << (8 * i));
      end
      if (!f3[2] && size < 4 && exp_ld[8*size-1]) exp_ld = exp_ld | (32'hFFFFFFFF << (8 * size));
    end
    exp_mask = 4'h0; lane_bits = 32'h0; exp_raw = 32'h0;
    if (ok && wr) begin
      for (int i = 0; i < size; i++) begin
        lane = 3 - (off + i);
        exp_mask[lane] = 1'b1;
        lane_bits = lane_bits | (32'hFF << (8 * lane));
        exp_raw   = exp_raw | (((wd >> (8 * i)) & 32'hFF) << (8 * lane));
      end
    end
    #1;
    check("req_we", sramWriteEnableB, exp_we);
    check("req_addr", sramAddressB, exp_addr);
    last_mask = sramByteMaskB; last_wdata = sramWriteB; last_we = sramWriteEnableB;
    if (exp_we) begin
      check("req_mask", sramByteMaskB, exp_mask);
      check("req_lanes", sramWriteB & lane_bits, exp_raw);
    end
    if (ok && wr) begin
      for (int i = 0; i < size; i++) begin
        if (in_ram) ref_mem[a + i] = wd[8*i +: 8];
        else ref_mmio[idx] = (ref_mmio[idx] & ~(32'hFF << (8 * (off + i)))) |
                             (((wd >> (8 * i)) & 32'hFF) << (8 * (off + i)));
      end
    end
    ref_fs = ref_fs | {exp_af, exp_mis};
    @(posedge clock); #1;
    check("rsp_load", loadData, exp_ld);
    check("rsp_misaligned", misaligned, exp_mis);
    check("rsp_fault", accessFault, exp_af);
`ifdef JZJPCC_LSU_STICKY_FAULT_EN
    check("rsp_status", faultStatus, ref_fs);
`else
    check("rsp_status", faultStatus, 2'b00);
`endif
    for (int j = 0; j < 8; j++) check($sformatf("mmio_out%0d", j), mmioOutputs[j], ref_mmio[j]);
    $display("op rd=%0d wr=%0d f3=%0d addr=%h wd=%h -> load=%h mis=%0d af=%0d",
             rd, wr, f3, a, wd, loadData, misaligned, accessFault);
    o_ld = loadData;
    memRead = 1'b0; memWrite = 1'b0;
  endtask

  // Store to MMIO word 0 while reset is held: nothing may land, everything reads zero.
  task automatic reset_with_store();
    reset = 1'b1; stall = 1'b0; memRead = 1'b0; memWrite = 1'b1; funct3 = 3'b010;
    address = MMIO_BASE; writeData = $urandom;
    #1;
    check("rst_req_we", sramWriteEnableB, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    for (int j = 0; j < 8; j++) check($sformatf("rst_mmio%0d", j), mmioOutputs[j], 32'h0);
    check("rst_load", loadData, 32'h0);
    check("rst_misaligned", misaligned, 1'b0);
    check("rst_fault", accessFault, 1'b0);
    check("rst_status", faultStatus, 2'b00);
    check("rst_we", sramWriteEnableB, 1'b0);
    check("rst_addr", sramAddressB, 12'h000);
    $display("reset with MMIO store: mmio0=%h load=%h", mmioOutputs[0], loadData);
    for (int j = 0; j < 8; j++) ref_mmio[j] = 32'h0;
    last_addr = 12'h000;
    ref_fs    = 2'b00;
    reset = 1'b0; memWrite = 1'b0;
  endtask

  initial begin
    logic [31:0] ld;
    logic [31:0] a;
    logic [2:0]  f3;
    bit          rd, wr;
    int          kind, region;
    for (int j = 0; j < 8; j++) mmioInputs[j] = $urandom;

    reset_with_store();

    // Word store/load round trip and byte-order checks
    do_op(0, 1, 3'b010, 32'h10, 32'h11223344, ld);
    check("tp_sw_mask", last_mask, 4'b1111);
    check("tp_sw_data", last_wdata, 32'h44332211);
    do_op(1, 0, 3'b010, 32'h10, 32'h0, ld);
    check("tp_lw", ld, 32'h11223344);
    do_op(1, 0, 3'b000, 32'h13, 32'h0, ld);
    check("tp_lb13", ld, 32'h00000011);
    do_op(1, 0, 3'b001, 32'h12, 32'h0, ld);
    check("tp_lh12", ld, 32'h00001122);
    do_op(0, 1, 3'b000, 32'h11, 32'h00000080, ld);
    check("tp_sb_mask", last_mask, 4'b0100);
    do_op(1, 0, 3'b000, 32'h11, 32'h0, ld);
    check("tp_lb11", ld, 32'hFFFFFF80);
    do_op(1, 0, 3'b100, 32'h11, 32'h0, ld);
    check("tp_lbu11", ld, 32'h00000080);

    // MMIO halfword store and word load
    do_op(0, 1, 3'b001, MMIO_BASE + 6, 32'h0000BEEF, ld);
    check("tp_mmio_sh", mmioOutputs[1], 32'hBEEF0000);
    mmioInputs[1] = 32'hCAFEF00D;
    do_op(1, 0, 3'b010, MMIO_BASE + 4, 32'h0, ld);
    check("tp_mmio_lw", ld, 32'hCAFEF00D);

    // Misaligned load and unmapped store
    do_op(1, 0, 3'b010, 32'h2, 32'h0, ld);
    check("tp_mis_we", last_we, 1'b0);
    check("tp_mis_flag", misaligned, 1'b1);
    do_op(0, 1, 3'b010, 32'h80000000, 32'hDEADBEEF, ld);
    check("tp_af_we", last_we, 1'b0);
    check("tp_af_flag", accessFault, 1'b1);
`ifdef JZJPCC_LSU_STICKY_FAULT_EN
    check("tp_status", faultStatus, 2'b11);
`endif

    // Stall holds the load result and the SRAM address
    do_op(0, 1, 3'b010, 32'h10, 32'h11223344, ld);
    do_op(1, 0, 3'b010, 32'h10, 32'h0, ld);
    for (int s = 0; s < 3; s++) begin
      stall = 1'b1; memRead = (s != 1); memWrite = (s == 1); funct3 = 3'b010;
      address = (s == 2) ? MMIO_BASE : ($urandom & 32'h00000FFC);
      writeData = $urandom;
      #1;
      check("stall_addr", sramAddressB, 12'h004);
      check("stall_we", sramWriteEnableB, 1'b0);
      @(posedge clock); #1;
      check("stall_load", loadData, 32'h11223344);
      check("stall_mmio0", mmioOutputs[0], ref_mmio[0]);
      $display("stall cycle %0d: addr=%h sramAddressB=%h load=%h", s, address, sramAddressB, loadData);
    end
    stall = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    @(posedge clock); #1;
    check("unstall_idle_load", loadData, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      for (int j = 0; j < 8; j++) mmioInputs[j] = $urandom;
      kind = $urandom_range(0, 9);
      rd = (kind <= 3) || (kind == 8);
      wr = (kind >= 4) && (kind <= 8);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, rd ? 4 : 2))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      region = $urandom_range(0, 5);
      case (region)
        0, 1:    a = $urandom_range(0, 63);
        2:       a = 32'h3FC0 + $urandom_range(0, 63);
        3, 4:    a = MMIO_BASE + $urandom_range(0, 31);
        default: a = ($urandom_range(0, 1) == 0) ? (32'h4000 + $urandom_range(0, 63))
                                                 : (32'h80000000 | $urandom);
      endcase
      do_op(rd, wr, f3, a, $urandom, ld);
    end

    reset_with_store();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
